wave_readout_streamer: RTL and testbench

WAVE_READOUT_STREAMER -- requirements
Module: wave_readout_streamer

---
 rtl/wave_readout_streamer.sv | 130 +++++++++++++
 tb/tb_wave_readout_streamer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/wave_readout_streamer.sv
// Streams one waveform as a byte packet: 2-byte marker, 2-byte wave number, then NUM_SAMPLES 16-bit samples MSB first.
// Each sample costs 1+READ_LATENCY fetch cycles; tx_ready low stalls the current byte with all outputs held.
module wave_readout_streamer #(
  parameter int          NUM_SAMPLES  = 1000,
  parameter int          READ_LATENCY = 2,
  parameter logic [15:0] HEADER       = 16'h5741
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] waveNumber,
  input  logic [15:0] waveSample,
  output logic [15:0] SampleNum,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] HDR     = 3'd1;
  localparam logic [2:0] FETCH   = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] SEND_HI = 3'd4;
  localparam logic [2:0] SEND_LO = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);
  localparam logic [3:0]  LAT_LAST = 4'(READ_LATENCY - 1);

  logic [2:0]  state;
  logic [15:0] wnReg;
  logic [15:0] holdReg;
  logic [15:0] sampleIdx;
  logic [1:0]  byteCnt;
  logic [3:0]  waitCnt;
  logic        beat;

  assign beat = tx_valid && tx_ready;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wnReg     <= '0;
      holdReg   <= '0;
      sampleIdx <= '0;
      byteCnt   <= '0;
      waitCnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wnReg     <= waveNumber;
            sampleIdx <= '0;
            byteCnt   <= '0;
            waitCnt   <= '0;
            state     <= HDR;
          end
        end
        HDR: begin
          if (beat) begin
            byteCnt <= byteCnt + 2'd1;
            if (byteCnt == 2'd3) state <= FETCH;
          end
        end
        FETCH: begin
          waitCnt <= '0;
          state   <= WAIT;
        end
        // The address has been stable since FETCH, so after READ_LATENCY wait cycles the data is settled.
        WAIT: begin
          if (waitCnt == LAT_LAST) begin
            holdReg <= waveSample;
            waitCnt <= '0;
            state   <= SEND_HI;
          end else begin
            waitCnt <= waitCnt + 4'd1;
          end
        end
        SEND_HI: begin
          if (beat) state <= SEND_LO;
        end
        SEND_LO: begin
          if (beat) begin
            if (sampleIdx == LAST_IDX) begin
              state <= DONE;
            end else begin
              sampleIdx <= sampleIdx + 16'd1;
              state     <= FETCH;
            end
          end
        end
        DONE: begin
          sampleIdx <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only, so they are stable while stalled and clear with reset.
  always_comb begin
    tx_data = 8'h00;
    case (state)
      HDR: begin
        case (byteCnt)
          2'd0: tx_data = HEADER[15:8];
          2'd1: tx_data = HEADER[7:0];
          2'd2: tx_data = wnReg[15:8];
          default: tx_data = wnReg[7:0];
        endcase
      end
      SEND_HI: tx_data = holdReg[15:8];
      SEND_LO: tx_data = holdReg[7:0];
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid  = (state == HDR) || (state == SEND_HI) || (state == SEND_LO);
  assign tx_sop    = (state == HDR) && (byteCnt == 2'd0);
  assign tx_eop    = (state == SEND_LO) && (sampleIdx == LAST_IDX);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign SampleNum = sampleIdx;

endmodule

// File: tb/tb_wave_readout_streamer.sv
// Scoreboard bench: three instances (4 samples/latency 3, 1000 samples, 1 sample) exercised one after another.
module tb_wave_readout_streamer;

  logic             clk;
  logic             rst;
  logic [2:0]       start;
  logic [2:0][15:0] waveNumber;
  logic [2:0][15:0] waveSample;
  logic [2:0][15:0] sampleNum;
  logic [2:0][7:0]  txData;
  logic [2:0]       txValid;
  logic [2:0]       txReady;
  logic [2:0]       txSop;
  logic [2:0]       txEop;
  logic [2:0]       busy;
  logic [2:0]       done;
  logic [2:0][2:0][15:0] snDly;

  int   nChecks = 0;
  int   nFail   = 0;
  bit   randReady = 0;
  logic [11:0] expQ[$];
  logic [11:0] expItem;
  logic [2:0]  prevStall;
  logic [10:0] prevBeat [3];

  wave_readout_streamer #(.NUM_SAMPLES(4), .READ_LATENCY(3)) dutA (
    .sys_clk(clk), .reset(rst), .start(start[0]), .waveNumber(waveNumber[0]),
    .waveSample(waveSample[0]), .SampleNum(sampleNum[0]), .tx_data(txData[0]),
    .tx_valid(txValid[0]), .tx_ready(txReady[0]), .tx_sop(txSop[0]), .tx_eop(txEop[0]),
    .busy(busy[0]), .done(done[0]));

  wave_readout_streamer dutB (
    .sys_clk(clk), .reset(rst), .start(start[1]), .waveNumber(waveNumber[1]),
    .waveSample(waveSample[1]), .SampleNum(sampleNum[1]), .tx_data(txData[1]),
    .tx_valid(txValid[1]), .tx_ready(txReady[1]), .tx_sop(txSop[1]), .tx_eop(txEop[1]),
    .busy(busy[1]), .done(done[1]));

  wave_readout_streamer #(.NUM_SAMPLES(1)) dutC (
    .sys_clk(clk), .reset(rst), .start(start[2]), .waveNumber(waveNumber[2]),
    .waveSample(waveSample[2]), .SampleNum(sampleNum[2]), .tx_data(txData[2]),
    .tx_valid(txValid[2]), .tx_ready(txReady[2]), .tx_sop(txSop[2]), .tx_eop(txEop[2]),
    .busy(busy[2]), .done(done[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Capture-memory model: data for an address appears exactly N clocks after the address changes.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      snDly[k][0] <= sampleNum[k];
      snDly[k][1] <= snDly[k][0];
      snDly[k][2] <= snDly[k][1];
    end
  end

  assign waveSample[0] = 16'hA000 + snDly[0][2];
  assign waveSample[1] = snDly[1][1] * 16'd257 + 16'h1234;
  assign waveSample[2] = 16'hBEEF;

  initial begin
    txReady = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      if (randReady) txReady = 3'($urandom_range(0, 7));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] expSample(input int k, input int i);
    if (k == 0) return 16'hA000 + 16'(i);
    if (k == 1) return 16'(i * 257) + 16'h1234;
    return 16'hBEEF;
  endfunction

  task automatic pushPacket(input int k, input logic [15:0] wn, input int n);
    logic [15:0] s;
    expQ.push_back({2'(k), 2'b10, 8'h57});
    expQ.push_back({2'(k), 2'b00, 8'h41});
    expQ.push_back({2'(k), 2'b00, wn[15:8]});
    expQ.push_back({2'(k), 2'b00, wn[7:0]});
    for (int i = 0; i < n; i++) begin
      s = expSample(k, i);
      expQ.push_back({2'(k), 2'b00, s[15:8]});
      expQ.push_back({2'(k), 1'b0, (i == n - 1), s[7:0]});
    end
  endtask

  task automatic doStart(input int k);
    @(posedge clk);
    #1 start[k] = 1'b1;
    @(posedge clk);
    #1 start[k] = 1'b0;
    chk("busy_after_start", 32'(busy[k]), 32'd1);
    chk("sop_first", {30'd0, txValid[k], txSop[k]}, 32'd3);
  endtask

  task automatic waitDone(input int k, input int budget);
    bit found = 0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (done[k]) found = 1;
    end
    chk("done_pulse", 32'(found), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done[k]), 32'd0);
    chk("idle_after_done", {14'd0, busy[k], txValid[k], sampleNum[k]}, 32'd0);
  endtask

  task automatic chkZero(input string name, input int k);
    chk(name, {5'd0, txValid[k], txSop[k], txEop[k], busy[k], done[k], txData[k], sampleNum[k]}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prevStall = '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (prevStall[k])
          chk("stall_hold", {21'd0, txValid[k], txSop[k], txEop[k], txData[k]}, {21'd0, prevBeat[k]});
        if (txValid[k] && txReady[k]) begin
          if (expQ.size() == 0) begin
            nChecks++;
            nFail++;
            $display("FAIL unexpected_beat: inst %0d byte %0h with no packet expected", k, txData[k]);
          end else begin
            expItem = expQ.pop_front();
            chk("beat", {20'd0, 2'(k), txSop[k], txEop[k], txData[k]}, {20'd0, expItem});
          end
        end
        prevStall[k] = txValid[k] && !txReady[k];
        prevBeat[k]  = {txValid[k], txSop[k], txEop[k], txData[k]};
      end
    end
  end

  initial begin
    bit found;
    rst        = 1'b1;
    start      = '0;
    waveNumber = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chkZero("reset_state", k);
    rst = 1'b0;

    // 4-sample packet, latency 3, waveNumber changed and start re-pulsed mid-packet
    waveNumber[0] = 16'h0012;
    pushPacket(0, 16'h0012, 4);
    doStart(0);
    waveNumber[0] = 16'hFFFF;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (sampleNum[0] == 16'd2 && txValid[0]) found = 1;
    end
    chk("reach_sample2_hi", 32'(found), 32'd1);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    waitDone(0, 200);
    repeat (20) @(posedge clk);
    #1;
    chk("no_second_packet", {31'd0, busy[0]}, 32'd0);
    chk("queue_empty_A", 32'(expQ.size()), 32'd0);

    // single-sample packet
    waveNumber[2] = 16'hC3A5;
    pushPacket(2, 16'hC3A5, 1);
    doStart(2);
    waitDone(2, 100);

    // 1000-sample packet with random stalls, reset at sample 500
    randReady = 1;
    waveNumber[1] = 16'h0777;
    pushPacket(1, 16'h0777, 1000);
    doStart(1);
    found = 0;
    for (int c = 0; c < 20000 && !found; c++) begin
      @(negedge clk);
      if (sampleNum[1] == 16'd500) found = 1;
    end
    chk("reach_sample500", 32'(found), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chkZero("reset_mid_packet", 1);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("idle_after_reset", {30'd0, busy[1], txValid[1]}, 32'd0);

    waveNumber[1] = 16'h4D2E;
    pushPacket(1, 16'h4D2E, 1000);
    doStart(1);
    waveNumber[1] = 16'h0000;
    waitDone(1, 30000);
    randReady = 0;
    @(posedge clk);
    #2 txReady = 3'b111;
    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
